// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: queued request, arbiter state, default queue depth.
package wb_pkg;

   localparam int WB_FIFO_DEPTH = 2;

   typedef struct packed {
      logic [4:0]  rd_num;
      logic [31:0] data;
      logic        valid;
   } wb_req_t;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HALT_WAIT = 2'd1,
      HALTED    = 2'd2
   } wb_arb_state_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline request, mult/div result handshake, register-file write.
// Handshake: an md result transfers on a cycle where md_valid and md_ready are both high;
// md_ready never depends on md_valid. The pipeline holds its write while pipe_stall is high.
interface wb_arbiter_if;
   logic        pipe_we;
   logic [4:0]  pipe_rd_num;
   logic [31:0] pipe_rd_data;
   logic        pipe_halted;
   logic        md_valid;
   logic [4:0]  md_rd_num;
   logic [31:0] md_data;
   logic        md_busy;
   logic        md_ready;
   logic        rf_we;
   logic [4:0]  rf_rd_num;
   logic [31:0] rf_rd_data;
   logic        pipe_stall;
   logic        halted;

   modport master (
      output pipe_we, pipe_rd_num, pipe_rd_data, pipe_halted,
      output md_valid, md_rd_num, md_data, md_busy,
      input  md_ready, rf_we, rf_rd_num, rf_rd_data, pipe_stall, halted
   );

   modport slave (
      input  pipe_we, pipe_rd_num, pipe_rd_data, pipe_halted,
      input  md_valid, md_rd_num, md_data, md_busy,
      output md_ready, rf_we, rf_rd_num, rf_rd_data, pipe_stall, halted
   );
endinterface

// File: rtl/wb_fifo.sv
// Mult/div result queue: power-of-2 depth, push/pop, occupancy count and
// invalidate-by-register so a younger pipeline write can kill stale results.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic                   push,
   input  wb_req_t                push_req,
   input  logic                   pop,
   input  logic                   inv_en,
   input  logic [4:0]             inv_rd,
   output wb_req_t                head,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   wb_req_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign head = mem[rd_ptr];

   // Storage, pointers and count; an entry pushed this cycle is never hit by this cycle's invalidate.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (inv_en && mem[i].rd_num == inv_rd) mem[i].valid <= 1'b0;
         end
         if (push) begin
            mem[wr_ptr] <= push_req;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter between the pipeline and a queued mult/div unit,
// with a halt sequence that drains outstanding results before stopping.
// Optional WB_ARB_TRACE_EN: prints each rf write and state change with a cycle count.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
   input  logic          clk,
   input  logic          rst_b,
   wb_arbiter_if.slave   bus,
   output wb_arb_state_t dbg_state
);
   localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

   wb_arb_state_t state, state_nxt;
   wb_req_t       head;
   logic [CW-1:0] count;
   logic          q_empty, q_full, push, pop, inv_en, head_we;
   logic          grant_we;
   logic [4:0]    grant_rd;
   logic [31:0]   grant_data;

   assign q_empty      = (count == '0);
   assign q_full       = (count == FULL_CNT);
   assign head_we      = head.valid && (head.rd_num != 5'd0);
   assign bus.md_ready = rst_b && !q_full && (state != HALTED);
   // Results for register 0 are accepted but never stored.
   assign push         = bus.md_valid && bus.md_ready && (bus.md_rd_num != 5'd0);
   assign dbg_state    = state;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_b    (rst_b),
      .push     (push),
      .push_req ('{rd_num: bus.md_rd_num, data: bus.md_data, valid: 1'b1}),
      .pop      (pop),
      .inv_en   (inv_en),
      .inv_rd   (bus.pipe_rd_num),
      .head     (head),
      .count    (count)
   );

   // Grant selection, stall and next state: a full queue wins over the pipe, else the pipe wins.
   always_comb begin
      state_nxt      = state;
      pop            = 1'b0;
      inv_en         = 1'b0;
      grant_we       = 1'b0;
      grant_rd       = head.rd_num;
      grant_data     = head.data;
      bus.pipe_stall = 1'b0;
      unique case (state)
         RUN: begin
            if (q_full && bus.pipe_we) begin
               pop            = 1'b1;
               grant_we       = head_we;
               bus.pipe_stall = rst_b;
            end else if (bus.pipe_we) begin
               inv_en     = 1'b1;
               grant_we   = (bus.pipe_rd_num != 5'd0);
               grant_rd   = bus.pipe_rd_num;
               grant_data = bus.pipe_rd_data;
               if (bus.pipe_halted)
                  state_nxt = (q_empty && !push && !bus.md_busy) ? HALTED : HALT_WAIT;
            end else if (!q_empty) begin
               pop      = 1'b1;
               grant_we = head_we;
            end
         end
         HALT_WAIT: begin
            if (!q_empty) begin
               pop      = 1'b1;
               grant_we = head_we;
            end else if (!push && !bus.md_busy) begin
               state_nxt = HALTED;
            end
         end
         HALTED: ;
         default: state_nxt = RUN;
      endcase
   end

   // State register and registered register-file write port.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state          <= RUN;
         bus.rf_we      <= 1'b0;
         bus.rf_rd_num  <= 5'd0;
         bus.rf_rd_data <= 32'd0;
         bus.halted     <= 1'b0;
      end else begin
         state      <= state_nxt;
         bus.rf_we  <= grant_we;
         bus.halted <= (state_nxt == HALTED);
         if (grant_we) begin
            bus.rf_rd_num  <= grant_rd;
            bus.rf_rd_data <= grant_data;
         end
      end
   end

`ifdef WB_ARB_TRACE_EN
   logic [31:0] cycle_cnt;

   // Cycle counter and trace of rf writes and state changes.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (grant_we)
            $display("[%0d] rf write %s rd=%0d data=0x%08h", cycle_cnt,
                     (state == RUN && bus.pipe_we && !q_full) ? "PIPE" : "MD", grant_rd, grant_data);
         if (state_nxt != state)
            $display("[%0d] state %s -> %s", cycle_cnt, state.name(), state_nxt.name());
      end
   end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with hand-derived expectations, then
// randomized traffic checked against a queue-based reference model.
module tb_wb_arbiter;
   import wb_pkg::*;

   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst_b;
   wb_arb_state_t dbg_state;
   int            n_checks = 0;
   int            n_fail   = 0;

   // Reference queue entries: {live, rd_num, data}
   logic [37:0]   exp_q[$];

   wb_arbiter_if bus();

   wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock and reset
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pipe_we      = 1'b0;
      bus.pipe_rd_num  = 5'd0;
      bus.pipe_rd_data = 32'd0;
      bus.pipe_halted  = 1'b0;
      bus.md_valid     = 1'b0;
      bus.md_rd_num    = 5'd0;
      bus.md_data      = 32'd0;
      bus.md_busy      = 1'b0;
   endtask

   task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] d, input logic hlt);
      bus.pipe_we      = 1'b1;
      bus.pipe_rd_num  = rd;
      bus.pipe_rd_data = d;
      bus.pipe_halted  = hlt;
   endtask

   task automatic drive_md(input logic [4:0] rd, input logic [31:0] d);
      bus.md_valid  = 1'b1;
      bus.md_rd_num = rd;
      bus.md_data   = d;
   endtask

   task automatic do_reset();
      idle();
      rst_b = 1'b0;
      tick();
      tick();
      rst_b = 1'b1;
   endtask

   // Reference model: pop the head of the queue and produce its rf write, if live
   function automatic void model_pop(output logic we, output logic [4:0] rd, output logic [31:0] d);
      logic [37:0] h;
      h  = exp_q.pop_front();
      we = h[37] && (h[36:32] != 5'd0);
      rd = h[36:32];
      d  = h[31:0];
   endfunction

   task automatic test_reset();
      idle();
      bus.md_valid = 1'b1;
      bus.pipe_we  = 1'b1;
      rst_b = 1'b0;
      tick();
      tick();
      n_checks++; if (bus.md_ready !== 1'b0) begin n_fail++; $display("FAIL reset_md_ready: got %b expected 0", bus.md_ready); end
      n_checks++; if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL reset_pipe_stall: got %b expected 0", bus.pipe_stall); end
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b expected 0", bus.rf_we); end
      n_checks++; if (bus.rf_rd_num !== 5'd0 || bus.rf_rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rf_addr_data: got %0d/%h expected 0/0", bus.rf_rd_num, bus.rf_rd_data); end
      n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
      n_checks++; if (dbg_state !== RUN) begin n_fail++; $display("FAIL reset_state: got %0d expected RUN", dbg_state); end
      rst_b = 1'b1;
      idle();
      #1;
      n_checks++; if (bus.md_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_md_ready: got %b expected 1", bus.md_ready); end
      tick();
   endtask

   task automatic test_pipe_write();
      do_reset();
      drive_pipe(5'd5, 32'h1234, 1'b0);
      #1;
      n_checks++; if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL pipe_stall_idle: got %b expected 0", bus.pipe_stall); end
      tick();
      idle();
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_num !== 5'd5 || bus.rf_rd_data !== 32'h0000_1234) begin n_fail++; $display("FAIL pipe_write: got we=%b rd=%0d d=%h expected 1/5/00001234", bus.rf_we, bus.rf_rd_num, bus.rf_rd_data); end
      tick();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL pipe_write_end: rf_we=%b expected 0", bus.rf_we); end
   endtask

   task automatic test_md_latency();
      do_reset();
      drive_md(5'd7, 32'hCAFE);
      #1;
      n_checks++; if (bus.md_ready !== 1'b1) begin n_fail++; $display("FAIL md_ready_empty: got %b expected 1", bus.md_ready); end
      tick();
      idle();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL md_no_bypass: rf_we=%b expected 0", bus.rf_we); end
      tick();
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_num !== 5'd7 || bus.rf_rd_data !== 32'h0000_CAFE) begin n_fail++; $display("FAIL md_write: got we=%b rd=%0d d=%h expected 1/7/0000cafe", bus.rf_we, bus.rf_rd_num, bus.rf_rd_data); end
      tick();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL md_write_end: rf_we=%b expected 0", bus.rf_we); end
   endtask

   task automatic test_full_stall();
      do_reset();
      drive_pipe(5'd20, 32'h20, 1'b0); drive_md(5'd10, 32'hA);
      tick();
      drive_pipe(5'd21, 32'h21, 1'b0); drive_md(5'd11, 32'hB);
      #1;
      n_checks++; if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL stall_not_full: got %b expected 0", bus.pipe_stall); end
      tick();
      drive_pipe(5'd22, 32'h22, 1'b0); drive_md(5'd12, 32'hC);
      #1;
      n_checks++; if (bus.pipe_stall !== 1'b1) begin n_fail++; $display("FAIL stall_full: got %b expected 1", bus.pipe_stall); end
      n_checks++; if (bus.md_ready !== 1'b0) begin n_fail++; $display("FAIL md_ready_full: got %b expected 0", bus.md_ready); end
      tick();
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_num !== 5'd10 || bus.rf_rd_data !== 32'hA) begin n_fail++; $display("FAIL full_head_first: got we=%b rd=%0d d=%h expected 1/10/a", bus.rf_we, bus.rf_rd_num, bus.rf_rd_data); end
      bus.md_valid = 1'b0;
      #1;
      n_checks++; if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b expected 0", bus.pipe_stall); end
      tick();
      idle();
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_num !== 5'd22 || bus.rf_rd_data !== 32'h22) begin n_fail++; $display("FAIL full_pipe_after: got we=%b rd=%0d d=%h expected 1/22/22", bus.rf_we, bus.rf_rd_num, bus.rf_rd_data); end
      tick();
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_num !== 5'd11 || bus.rf_rd_data !== 32'hB) begin n_fail++; $display("FAIL full_second_entry: got we=%b rd=%0d d=%h expected 1/11/b", bus.rf_we, bus.rf_rd_num, bus.rf_rd_data); end
      tick();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL full_drained: rf_we=%b expected 0", bus.rf_we); end
   endtask

   task automatic test_invalidate();
      do_reset();
      drive_pipe(5'd3, 32'h3, 1'b0); drive_md(5'd9, 32'hDEAD);
      tick();
      idle();
      drive_pipe(5'd9, 32'h1, 1'b0);
      tick();
      idle();
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_num !== 5'd9 || bus.rf_rd_data !== 32'h1) begin n_fail++; $display("FAIL inv_pipe_write: got we=%b rd=%0d d=%h expected 1/9/1", bus.rf_we, bus.rf_rd_num, bus.rf_rd_data); end
      tick();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL inv_dropped: rf_we=%b rd=%0d d=%h expected no write", bus.rf_we, bus.rf_rd_num, bus.rf_rd_data); end
      tick();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL inv_empty: rf_we=%b expected 0", bus.rf_we); end
   endtask

   task automatic test_rd_zero_and_halt_now();
      do_reset();
      drive_pipe(5'd0, 32'h55, 1'b0);
      tick();
      idle();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_pipe: rf_we=%b expected 0", bus.rf_we); end
      drive_md(5'd0, 32'h66);
      tick();
      idle();
      tick();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_md_discard: rf_we=%b expected 0", bus.rf_we); end
      drive_pipe(5'd1, 32'h77, 1'b1);
      tick();
      idle();
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_num !== 5'd1 || bus.rf_rd_data !== 32'h77) begin n_fail++; $display("FAIL halt_write: got we=%b rd=%0d d=%h expected 1/1/77", bus.rf_we, bus.rf_rd_num, bus.rf_rd_data); end
      n_checks++; if (bus.halted !== 1'b1 || dbg_state !== HALTED) begin n_fail++; $display("FAIL halt_now: halted=%b state=%0d expected 1/HALTED", bus.halted, dbg_state); end
      drive_md(5'd4, 32'h4);
      drive_pipe(5'd8, 32'h8, 1'b0);
      #1;
      n_checks++; if (bus.md_ready !== 1'b0) begin n_fail++; $display("FAIL halted_md_ready: got %b expected 0", bus.md_ready); end
      tick();
      idle();
      n_checks++; if (bus.rf_we !== 1'b0 || bus.halted !== 1'b1) begin n_fail++; $display("FAIL halted_hold: rf_we=%b halted=%b expected 0/1", bus.rf_we, bus.halted); end
   endtask

   task automatic test_halt_drain();
      do_reset();
      drive_pipe(5'd2, 32'h2, 1'b0); drive_md(5'd14, 32'h14);
      tick();
      idle();
      drive_pipe(5'd4, 32'h44, 1'b1);
      bus.md_busy = 1'b1;
      tick();
      n_checks++; if (dbg_state !== HALT_WAIT || bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_wait_enter: state=%0d halted=%b expected HALT_WAIT/0", dbg_state, bus.halted); end
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_num !== 5'd4) begin n_fail++; $display("FAIL halt_pipe_write: we=%b rd=%0d expected 1/4", bus.rf_we, bus.rf_rd_num); end
      drive_pipe(5'd6, 32'h6, 1'b0);
      #1;
      n_checks++; if (bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL halt_wait_stall: got %b expected 0", bus.pipe_stall); end
      tick();
      n_checks++; if (bus.rf_we !== 1'b1 || bus.rf_rd_num !== 5'd14 || bus.rf_rd_data !== 32'h14) begin n_fail++; $display("FAIL halt_drain: got we=%b rd=%0d d=%h expected 1/14/14", bus.rf_we, bus.rf_rd_num, bus.rf_rd_data); end
      bus.pipe_we = 1'b0;
      tick();
      n_checks++; if (dbg_state !== HALT_WAIT || bus.halted !== 1'b0 || bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL halt_busy_wait: state=%0d halted=%b we=%b expected HALT_WAIT/0/0", dbg_state, bus.halted, bus.rf_we); end
      bus.md_busy = 1'b0;
      tick();
      n_checks++; if (dbg_state !== HALTED || bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_done: state=%0d halted=%b expected HALTED/1", dbg_state, bus.halted); end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      drive_pipe(5'd2, 32'h2, 1'b0); drive_md(5'd15, 32'h15);
      tick();
      drive_pipe(5'd3, 32'h3, 1'b1); drive_md(5'd16, 32'h16);
      bus.md_busy = 1'b1;
      tick();
      n_checks++; if (dbg_state !== HALT_WAIT) begin n_fail++; $display("FAIL mid_drain_setup: state=%0d expected HALT_WAIT", dbg_state); end
      idle();
      rst_b = 1'b0;
      #1;
      n_checks++; if (bus.md_ready !== 1'b0 || bus.pipe_stall !== 1'b0) begin n_fail++; $display("FAIL mid_drain_rst_comb: md_ready=%b stall=%b expected 0/0", bus.md_ready, bus.pipe_stall); end
      tick();
      n_checks++; if (dbg_state !== RUN || bus.rf_we !== 1'b0 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL mid_drain_rst: state=%0d we=%b halted=%b expected RUN/0/0", dbg_state, bus.rf_we, bus.halted); end
      rst_b = 1'b1;
      tick();
      tick();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_drain_queue_empty: rf_we=%b rd=%0d expected no write", bus.rf_we, bus.rf_rd_num); end
   endtask

   task automatic test_random();
      wb_arb_state_t m_state;
      logic          e_ready, e_stall, e_we, enq;
      logic [4:0]    e_rd;
      logic [31:0]   e_data;
      do_reset();
      exp_q.delete();
      m_state = RUN;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst_b            = (m_state == HALTED) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) != 0);
         bus.pipe_we      = $urandom_range(0, 1);
         bus.pipe_rd_num  = 5'($urandom_range(0, 31));
         bus.pipe_rd_data = $urandom;
         bus.pipe_halted  = ($urandom_range(0, 29) == 0);
         bus.md_valid     = $urandom_range(0, 1);
         bus.md_rd_num    = 5'($urandom_range(0, 31));
         bus.md_data      = $urandom;
         bus.md_busy      = ($urandom_range(0, 3) == 0);
         if (bus.pipe_we && bus.md_valid && bus.pipe_rd_num == bus.md_rd_num) bus.md_valid = 1'b0;

         e_we    = 1'b0;
         e_stall = 1'b0;
         e_rd    = 5'd0;
         e_data  = 32'd0;
         e_ready = rst_b && (exp_q.size() < DEPTH) && (m_state != HALTED);
         enq     = bus.md_valid && e_ready && (bus.md_rd_num != 5'd0);
         if (!rst_b) begin
            exp_q.delete();
            m_state = RUN;
         end else if (m_state == RUN) begin
            if (exp_q.size() == DEPTH && bus.pipe_we) begin
               e_stall = 1'b1;
               model_pop(e_we, e_rd, e_data);
            end else if (bus.pipe_we) begin
               e_we   = (bus.pipe_rd_num != 5'd0);
               e_rd   = bus.pipe_rd_num;
               e_data = bus.pipe_rd_data;
               foreach (exp_q[i]) if (exp_q[i][36:32] == bus.pipe_rd_num) exp_q[i][37] = 1'b0;
               if (bus.pipe_halted)
                  m_state = (exp_q.size() == 0 && !enq && !bus.md_busy) ? HALTED : HALT_WAIT;
            end else if (exp_q.size() != 0) begin
               model_pop(e_we, e_rd, e_data);
            end
         end else if (m_state == HALT_WAIT) begin
            if (exp_q.size() != 0) model_pop(e_we, e_rd, e_data);
            else if (!enq && !bus.md_busy) m_state = HALTED;
         end
         if (rst_b && enq) exp_q.push_back({1'b1, bus.md_rd_num, bus.md_data});

         #1;
         n_checks++; if (bus.md_ready !== e_ready) begin n_fail++; $display("FAIL rnd_md_ready cyc %0d: got %b expected %b", cyc, bus.md_ready, e_ready); end
         n_checks++; if (bus.pipe_stall !== e_stall) begin n_fail++; $display("FAIL rnd_pipe_stall cyc %0d: got %b expected %b", cyc, bus.pipe_stall, e_stall); end
         tick();
         n_checks++; if (bus.rf_we !== e_we) begin n_fail++; $display("FAIL rnd_rf_we cyc %0d: got %b expected %b", cyc, bus.rf_we, e_we); end
         if (e_we || !rst_b) begin
            n_checks++; if (bus.rf_rd_num !== e_rd || bus.rf_rd_data !== e_data) begin n_fail++; $display("FAIL rnd_rf_data cyc %0d: got rd=%0d d=%h expected rd=%0d d=%h", cyc, bus.rf_rd_num, bus.rf_rd_data, e_rd, e_data); end
         end
         n_checks++; if (bus.halted !== (m_state == HALTED)) begin n_fail++; $display("FAIL rnd_halted cyc %0d: got %b expected %b", cyc, bus.halted, (m_state == HALTED)); end
         n_checks++; if (dbg_state !== m_state) begin n_fail++; $display("FAIL rnd_state cyc %0d: got %0d expected %0d", cyc, dbg_state, m_state); end
      end
   endtask

   // Test sequence and final report
   initial begin
      idle();
      rst_b = 1'b0;
      test_reset();
      test_pipe_write();
      test_md_latency();
      test_full_stall();
      test_invalidate();
      test_rd_zero_and_halt_now();
      test_halt_drain();
      test_reset_mid_drain();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: entries in the multiply/divide result queue (power of 2, at least 2).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port rst_b, input, 1: reset, synchronous and active-low, sampled on posedge clk.
REQ-004 SHALL have port pipe_we, input, 1: pipeline writeback request this cycle.
REQ-005 SHALL have port pipe_rd_num, input, 5: pipeline destination register.
REQ-006 SHALL have port pipe_rd_data, input, 32: pipeline write data.
REQ-007 SHALL have port pipe_halted, input, 1: halt instruction reached writeback.
REQ-008 SHALL have port md_valid, input, 1: mult/div unit offers a result.
REQ-009 SHALL have port md_rd_num, input, 5: mult/div destination register.
REQ-010 SHALL have port md_data, input, 32: mult/div result.
REQ-011 SHALL have port md_busy, input, 1: mult/div has an operation in flight.
REQ-012 SHALL have port md_ready, output, 1: queue can accept; high when count < FIFO_DEPTH and state is not HALTED.
REQ-013 SHALL have port rf_we, output, 1: registered register-file write enable.
REQ-014 SHALL have port rf_rd_num, output, 5: registered write address.
REQ-015 SHALL have port rf_rd_data, output, 32: registered write data.
REQ-016 SHALL have port pipe_stall, output, 1: combinational; pipeline holds its writeback this cycle.
REQ-017 SHALL have port halted, output, 1: registered; machine fully drained and stopped.

Function
REQ-018 SHALL accept an md result on a cycle where md_valid and md_ready are both high; a result for register 0 is accepted and discarded without being enqueued.
REQ-019 SHALL give a granted write its rf_we/rf_rd_num/rf_rd_data on the next posedge (1-cycle latency); an md result reaches rf no earlier than 2 cycles after acceptance (no bypass).
REQ-020 SHALL arbitrate in state RUN: if queue full and pipe_we high -> grant queue head, pipe_stall=1; else if pipe_we high -> grant pipe; else if queue non-empty -> grant head; else rf_we=0.
REQ-021 SHALL keep pipe_stall=0 whenever pipe_we=0 or the queue is not full.
REQ-022 SHALL suppress rf_we for any grant with rd_num 0; the grant still consumes its slot.
REQ-023 SHALL, on a granted pipe write to register N, invalidate every queued entry with rd_num N (the pipe write is younger); invalidated entries are dropped at dequeue without writing rf.
REQ-024 SHALL enqueue and dequeue in the same cycle when both apply; count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 SHALL use states RUN -> HALT_WAIT on a granted pipe cycle with pipe_halted=1 -> HALTED when queue empty and md_busy=0.
REQ-026 SHALL, in HALT_WAIT, keep draining the queue and accepting md results; pipe_we is ignored and pipe_stall=0.
REQ-027 SHALL, in HALTED, hold rf_we=0, md_ready=0 and halted=1 until reset.
REQ-028 SHALL move from RUN straight to HALTED on the next posedge if the halt is granted with the queue empty and md_busy=0.

Reset
REQ-029 SHALL, on posedge clk with rst_b=0, set state RUN, empty the queue, rf_we=0, rf_rd_num=0, rf_rd_data=0, halted=0 and cycle counter 0, aborting any mid-drain or halt sequence.
REQ-030 SHALL drive md_ready=0 and pipe_stall=0 while rst_b=0.

Configuration
REQ-031 SHALL, with WB_ARB_TRACE_EN defined, $display the cycle count, source (PIPE/MD), rd_num and data for each rf write, plus each state change.
REQ-032 SHALL, without WB_ARB_TRACE_EN, contain no $display and no cycle counter; all ports behave identically.

Structure
REQ-033 SHALL take the following from package wb_pkg: typedef wb_req_t (rd_num[4:0], data[31:0], valid), enum wb_arb_state_t {RUN, HALT_WAIT, HALTED}, and the default FIFO depth constant.
REQ-034 SHALL implement the queue as sub-module wb_fifo: parameterized depth, push/pop, count, per-entry invalidate-by-rd_num.

Verification
REQ-035 SHALL cover: pipe_we=1, rd=5, data=0x1234 -> next cycle rf_we=1, rf_rd_num=5, rf_rd_data=0x00001234.
REQ-036 SHALL cover: md result rd=7, 0xCAFE accepted with pipe idle -> rf write rd=7 two cycles later.
REQ-037 SHALL cover: two md results fill the queue, then pipe_we=1 -> pipe_stall=1, md_ready=0, the head drains first, then the pipe is granted.
REQ-038 SHALL cover: queued md rd=9, then pipe write rd=9 value 0x1 -> reg 9 is written only with 0x1; the md entry is dropped.
REQ-039 SHALL cover: halt granted with one queued entry and md_busy=1 for 3 cycles -> HALT_WAIT, entry drains, halted=1 the cycle after md_busy falls.
REQ-040 SHALL cover: rst_b=0 asserted while in HALT_WAIT with a non-empty queue -> next cycle RUN, queue empty, rf_we=0, halted=0.
